out_port_arbiter: RTL and testbench
===================================

# out_port_arbiter

- Round-robin output-port scheduler for one YaNoC router output link.
- Shares that link among the five input FIFOs (north, south, east, west, local).
- Holds the link for a whole fixed-length packet, issues read strobes to the winning FIFO and forwards its flits with a valid qualifier.
- One instance sits per router output port, between the input FIFOs and the output link.

## Interface
Parameters:
- PKT_LEN, 4, flits per packet; legal range 1..8.
- DW, 8, flit width; matches input FIFO data width.

Ports:
- clk  in  1  the single clock; all state updates on its rising edge.
- rst  in  1  reset, synchronous, active-high.
- req  in  5  per-input request, bit0=N, 1=S, 2=E, 3=W, 4=L; high = FIFO non-empty and its head packet routes to this port.
- data_in  in  5*DW  FIFO data outputs concatenated; input i on bits [i*DW +: DW].
- out_ready  in  1  downstream credit; high = downstream accepts a flit one cycle later.
- rd  out  5  read strobe to the input FIFOs; at most one bit high.
- grant  out  5  one-hot current owner; zero when idle.
- data_out  out  DW  forwarded flit.
- valid_out  out  1  data_out is a valid flit.
- busy  out  1  high while a packet is in transfer.

## Operation
- FSM states: IDLE, XFER.
- IDLE:
  - If req != 0, select the first set bit scanning from (last+1) mod 5 upward, wrapping 4->0.
  - Register it in grant, clear the flit counter cnt, go to XFER.
  - If req == 0, stay in IDLE.
- XFER:
  - rd[g] = req[g] & out_ready (combinational from registered state); all other rd bits stay 0.
  - On each cycle with rd[g]=1, cnt increments.
  - On the rd of flit PKT_LEN-1: last <= g, grant <= 0, go to IDLE.
- Stall: if req[g]=0 (FIFO momentarily empty) or out_ready=0 in XFER, no rd; grant, cnt and state hold. The packet is never abandoned.
- Requests from other inputs during XFER are ignored; no preemption.
- Datapath:
  - valid_out is rd[g] delayed one cycle (registered), since the FIFO data_out updates one cycle after its read.
  - sel_q is the registered index of the input read.
  - data_out = data_in[sel_q] when valid_out=1, else 0.
- busy = (state==XFER).
- cnt is 3 bits and wraps only via the return to IDLE; it never exceeds PKT_LEN-1.
- Reset values: state IDLE, grant 0, rd 0, cnt 0, last 4 (so north has first priority), sel_q 0, valid_out 0, data_out 0, busy 0.
- Reset asserted mid-packet: next edge returns all state to reset values. The partial packet is dropped from the arbiter's view; no further rd is issued.

## Timing
- req seen in IDLE at edge t:
  - grant registered at t+1.
  - First rd possible in cycle t+1.
  - First valid_out in cycle t+2.
- Steady state: one flit per cycle while req[g] and out_ready stay high.
- Packet of PKT_LEN flits with no stalls occupies PKT_LEN cycles of XFER plus one IDLE arbitration cycle. Back-to-back packets therefore carry one bubble cycle.
- valid_out lags rd by exactly one cycle, always, including across a stall or the final flit.
- Fairness: with all five requesting continuously, grant order is N,S,E,W,L,N,...; each waits at most 4 packets.

## Test plan
- Reset: hold rst 2 cycles with req=5'b11111 -> rd=0, grant=0, valid_out=0, data_out=0, busy=0 throughout; first grant after release is 5'b00001.
- Single requester: req=5'b00100, out_ready=1, E FIFO supplies 8'hA1..A4 -> grant=5'b00100 one cycle after req, rd[2] high 4 consecutive cycles, valid_out on the next 4 cycles with data_out A1,A2,A3,A4, then busy=0.
- Round robin: req=5'b10011 held, PKT_LEN=4 -> grants N, S, L, N in that order, each 4 rd pulses, one idle cycle between packets.
- Back-pressure: out_ready low for 3 cycles after flit 2 of a packet -> rd=0 for those 3 cycles, grant held, cnt held; flits 3-4 follow with no loss or duplication.
- FIFO underrun: req[g] drops for 2 cycles mid-packet -> no rd, no valid_out gap beyond those cycles, packet completes with exactly PKT_LEN valid flits.
- Reset mid-packet: assert rst after flit 2 -> next cycle grant=0 and rd=0; valid_out=0 one cycle after reset; arbitration restarts with north priority.

Source files
------------

// File: rtl/out_port_arbiter.sv
// Round-robin scheduler for one router output link: locks the link to one input FIFO for a
// whole PKT_LEN-flit packet, strobes its reads and forwards the flits one cycle later.
module out_port_arbiter #(
  parameter int PKT_LEN = 4,
  parameter int DW      = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [4:0]    req,
  input  logic [5*DW-1:0] data_in,
  input  logic          out_ready,
  output logic [4:0]    rd,
  output logic [4:0]    grant,
  output logic [DW-1:0] data_out,
  output logic          valid_out,
  output logic          busy
);

  typedef enum logic {IDLE, XFER} state_t;

  localparam logic [2:0] LAST_CNT = 3'(PKT_LEN - 1);

  state_t        state;
  logic [2:0]    g;
  logic [2:0]    last;
  logic [2:0]    sel_q;
  logic [2:0]    cnt;
  logic [2:0]    pick;
  logic [2:0]    idx;
  logic          found;
  logic [DW-1:0] lane [5];

  // Scan starts just past the previous winner so every input waits at most four packets.
  always_comb begin
    pick  = 3'd0;
    found = 1'b0;
    idx   = 3'd0;
    for (int k = 1; k <= 5; k++) begin
      idx = 3'((int'(last) + k) % 5);
      if (!found && req[idx]) begin
        found = 1'b1;
        pick  = idx;
      end
    end
  end

  // Reads are suppressed while reset is asserted so an aborted packet never pops a FIFO.
  always_comb begin
    rd = '0;
    if (state == XFER && !rst && out_ready && req[g])
      rd[g] = 1'b1;
  end

  always_comb begin
    for (int i = 0; i < 5; i++)
      lane[i] = data_in[i*DW +: DW];
  end

  assign data_out = valid_out ? lane[sel_q] : '0;
  assign busy     = (state == XFER);

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      grant     <= '0;
      g         <= 3'd0;
      cnt       <= 3'd0;
      last      <= 3'd4;
      sel_q     <= 3'd0;
      valid_out <= 1'b0;
    end else begin
      valid_out <= |rd;
      if (|rd)
        sel_q <= g;
      case (state)
        IDLE: begin
          if (|req) begin
            g     <= pick;
            grant <= 5'b00001 << pick;
            cnt   <= 3'd0;
            state <= XFER;
          end
        end
        XFER: begin
          if (|rd) begin
            if (cnt == LAST_CNT) begin
              last  <= g;
              grant <= '0;
              cnt   <= 3'd0;
              state <= IDLE;
            end else begin
              cnt <= cnt + 3'd1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_out_port_arbiter.sv
// Bench for out_port_arbiter: five modelled input FIFOs, a flit scoreboard, a per-cycle
// vector table and hand-written stall, fairness and mid-packet reset sequences.
module tb_out_port_arbiter;

  logic           clk = 1'b0;
  logic           rst;
  logic [4:0]     req;
  logic [4:0][7:0] din;
  logic [39:0]    data_in;
  logic           out_ready;
  logic [4:0]     rd;
  logic [4:0]     grant;
  logic [7:0]     data_out;
  logic           valid_out;
  logic           busy;

  assign data_in = din;

  out_port_arbiter #(.PKT_LEN(4), .DW(8)) dut (
    .clk(clk), .rst(rst), .req(req), .data_in(data_in), .out_ready(out_ready),
    .rd(rd), .grant(grant), .data_out(data_out), .valid_out(valid_out), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       rst;
    logic [4:0] mask;
    logic       ordy;
    logic [4:0] rd;
    logic [4:0] grant;
    logic       vld;
    logic       busy;
    logic [7:0] dout;
  } vec_t;

  vec_t       tbl [12];
  logic [7:0] fq [5][$];
  logic [7:0] exp_q [$];
  logic [4:0] glog [$];
  logic [4:0] mask;
  logic [4:0] rd_s;
  logic [4:0] prev_g;
  int         tests = 0;
  int         fails = 0;
  int         vcount;
  int         gap;
  int         pkt_rd;
  bit         mon_en;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Drive req from FIFO occupancy, then score the settled outputs before the next edge.
  task automatic sample();
    for (int i = 0; i < 5; i++) req[i] = mask[i] && (fq[i].size() != 0);
    #1;
    if (valid_out) begin
      vcount++;
      if (exp_q.size() == 0) check("sb_spurious_valid", 32'(data_out), 32'hFFFF_FFFF);
      else check("sb_data", 32'(data_out), 32'(exp_q.pop_front()));
    end
    check("rd_onehot", 32'($countones(rd) <= 1), 32'd1);
    rd_s = rd;
    for (int i = 0; i < 5; i++) begin
      if (rd[i]) begin
        if (fq[i].size() == 0) check("rd_empty_fifo", 32'(i), 32'hFFFF_FFFF);
        else exp_q.push_back(fq[i][0]);
      end
    end
    if (mon_en) begin
      if (grant != 5'd0) begin
        if (prev_g == 5'd0) begin
          glog.push_back(grant);
          if (glog.size() > 1) check("rr_gap", 32'(gap), 32'd1);
          gap    = 0;
          pkt_rd = 0;
        end
        pkt_rd += int'(|rd);
      end else begin
        if (prev_g != 5'd0) check("rr_pkt_len", 32'(pkt_rd), 32'd4);
        gap++;
      end
      prev_g = grant;
    end
  endtask

  // The FIFO output register updates one cycle after its read strobe.
  task automatic advance();
    @(posedge clk);
    for (int i = 0; i < 5; i++)
      if (rd_s[i] && fq[i].size() != 0) din[i] = fq[i].pop_front();
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    sample(); advance();
    sample(); advance();
    rst = 1'b0;
    exp_q.delete();
  endtask

  task automatic fill(input int i, input logic [7:0] base, input int n);
    for (int k = 0; k < n; k++) fq[i].push_back(base + 8'(k));
  endtask

  task automatic clear_fifos();
    for (int i = 0; i < 5; i++) fq[i].delete();
  endtask

  // Packet on N with either 3 cycles of out_ready low or 2 cycles of FIFO underrun after flit 2.
  task automatic stall_seq(input bit use_ready);
    int   len;
    logic exp_rd;
    logic exp_busy;
    string tag;
    len = use_ready ? 3 : 2;
    tag = use_ready ? "bp" : "ur";
    clear_fifos();
    fill(0, use_ready ? 8'hB1 : 8'hC1, 4);
    do_reset();
    vcount = 0;
    for (int c = 0; c < 10; c++) begin
      out_ready = !(use_ready && c >= 3 && c <= 5);
      mask      = (!use_ready && c >= 3 && c <= 4) ? 5'b00000 : 5'b00001;
      sample();
      exp_rd   = (c == 1 || c == 2 || c == 3 + len || c == 4 + len);
      exp_busy = (c >= 1 && c <= 4 + len);
      check({tag, "_rd"}, 32'(rd), exp_rd ? 32'd1 : 32'd0);
      check({tag, "_busy"}, 32'(busy), 32'(exp_busy));
      check({tag, "_grant"}, 32'(grant), exp_busy ? 32'd1 : 32'd0);
      advance();
    end
    check({tag, "_flits"}, 32'(vcount), 32'd4);
    check({tag, "_drain"}, 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    din       = '0;
    req       = '0;
    mask      = '0;
    rst       = 1'b1;
    out_ready = 1'b0;
    mon_en    = 1'b0;
    prev_g    = '0;
    rd_s      = '0;
    vcount    = 0;
    gap       = 0;
    pkt_rd    = 0;

    //          rst   mask      ordy  rd        grant     vld   busy  dout
    tbl[0]  = '{1'b1, 5'h1F,    1'b1, 5'h00,    5'h00,    1'b0, 1'b0, 8'h00};
    tbl[1]  = '{1'b1, 5'h1F,    1'b1, 5'h00,    5'h00,    1'b0, 1'b0, 8'h00};
    tbl[2]  = '{1'b0, 5'h1F,    1'b0, 5'h00,    5'h00,    1'b0, 1'b0, 8'h00};
    tbl[3]  = '{1'b0, 5'h1F,    1'b0, 5'h00,    5'h01,    1'b0, 1'b1, 8'h00};
    tbl[4]  = '{1'b1, 5'h1F,    1'b0, 5'h00,    5'h01,    1'b0, 1'b1, 8'h00};
    tbl[5]  = '{1'b0, 5'h04,    1'b1, 5'h00,    5'h00,    1'b0, 1'b0, 8'h00};
    tbl[6]  = '{1'b0, 5'h04,    1'b1, 5'h04,    5'h04,    1'b0, 1'b1, 8'h00};
    tbl[7]  = '{1'b0, 5'h04,    1'b1, 5'h04,    5'h04,    1'b1, 1'b1, 8'hA1};
    tbl[8]  = '{1'b0, 5'h04,    1'b1, 5'h04,    5'h04,    1'b1, 1'b1, 8'hA2};
    tbl[9]  = '{1'b0, 5'h04,    1'b1, 5'h04,    5'h04,    1'b1, 1'b1, 8'hA3};
    tbl[10] = '{1'b0, 5'h04,    1'b1, 5'h00,    5'h00,    1'b1, 1'b0, 8'hA4};
    tbl[11] = '{1'b0, 5'h04,    1'b1, 5'h00,    5'h00,    1'b0, 1'b0, 8'h00};

    fill(0, 8'h10, 4);
    fill(1, 8'h20, 4);
    fill(2, 8'hA1, 4);
    fill(3, 8'h40, 4);
    fill(4, 8'h50, 4);
    advance();

    for (int r = 0; r < 12; r++) begin
      rst       = tbl[r].rst;
      mask      = tbl[r].mask;
      out_ready = tbl[r].ordy;
      sample();
      check($sformatf("vec%0d_rd", r), 32'(rd), 32'(tbl[r].rd));
      check($sformatf("vec%0d_grant", r), 32'(grant), 32'(tbl[r].grant));
      check($sformatf("vec%0d_valid", r), 32'(valid_out), 32'(tbl[r].vld));
      check($sformatf("vec%0d_busy", r), 32'(busy), 32'(tbl[r].busy));
      check($sformatf("vec%0d_dout", r), 32'(data_out), 32'(tbl[r].dout));
      advance();
    end

    // Round robin over N, S and L holding requests continuously.
    clear_fifos();
    fill(0, 8'h00, 8);
    fill(1, 8'h30, 8);
    fill(4, 8'h60, 8);
    mask      = 5'b10011;
    out_ready = 1'b1;
    do_reset();
    glog.delete();
    prev_g = '0;
    gap    = 0;
    mon_en = 1'b1;
    for (int c = 0; c < 21; c++) begin
      sample();
      advance();
    end
    mon_en = 1'b0;
    check("rr_count", 32'(glog.size() >= 4), 32'd1);
    if (glog.size() >= 4) begin
      check("rr_g0", 32'(glog[0]), 32'h01);
      check("rr_g1", 32'(glog[1]), 32'h02);
      check("rr_g2", 32'(glog[2]), 32'h10);
      check("rr_g3", 32'(glog[3]), 32'h01);
    end

    stall_seq(1'b1);
    stall_seq(1'b0);

    // Reset in the middle of E's second packet must restart arbitration at north.
    clear_fifos();
    fill(2, 8'hE0, 8);
    fill(0, 8'h70, 4);
    fill(3, 8'h80, 4);
    fill(4, 8'h90, 4);
    mask      = 5'b00100;
    out_ready = 1'b1;
    do_reset();
    for (int c = 0; c < 8; c++) begin
      sample();
      if (c == 7) begin
        check("mr_pre_grant", 32'(grant), 32'h04);
        check("mr_pre_rd", 32'(rd), 32'h04);
      end
      advance();
    end
    rst  = 1'b1;
    mask = 5'b11111;
    sample(); advance();
    rst = 1'b0;
    sample();
    check("mr_grant", 32'(grant), 32'h00);
    check("mr_rd", 32'(rd), 32'h00);
    check("mr_valid", 32'(valid_out), 32'd0);
    check("mr_busy", 32'(busy), 32'd0);
    advance();
    sample();
    check("mr_restart_grant", 32'(grant), 32'h01);
    advance();
    exp_q.delete();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
